// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose
//   Central stall/flush sequencer for a 5-stage pipeline. It drives the load
//   enables of the PC, IF/ID, ID/EX and EX/MEM registers, and the bubble
//   (flush) inputs of IF/ID, ID/EX and MEM/WB. It handles three events:
//     - load-use hazards: the ID instruction is held for LOAD_BUBBLES cycles
//       while bubbles are fed into EX,
//     - taken branches resolved in EX: the two younger wrong-path
//       instructions are squashed,
//     - multi-cycle data-memory accesses: the whole pipe is frozen until
//       mem_ready arrives. If the wait lasts MEM_TIMEOUT cycles, the block
//       enters a sticky FAULT state.
//   The outputs are Mealy: they are combinational from the state and the
//   current inputs. A hazard therefore takes effect in the same cycle it is
//   detected.
//
// Parameters
//   REG_AW        register-address width
//   LOAD_BUBBLES  bubbles per load-use hazard, legal 1..3
//                 (1 = MEM->EX forwarding present)
//   MEM_TIMEOUT   MEM_WAIT cycles before FAULT; 0 disables the timeout
//   CNT_W         perf counter width (only with HAZARD_PERF_EN)
//
// Ports
//   clk, reset        pipeline clock; synchronous active-high reset
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rt        ID instruction actually reads rt
//   ex_dest           destination of the EX instruction (after RegDest mux)
//   ex_mem_to_reg     EX instruction is a load
//   ex_reg_write      EX instruction writes the register file
//   branch_taken      taken branch/jump resolved in EX this cycle
//   mem_req           MEM stage holds a load/store
//   mem_ready         data memory completes the MEM access this cycle
//   pc_en, ifid_en, idex_en, exmem_en      register load enables
//   ifid_flush, idex_flush, memwb_flush    force a bubble into that register
//   mem_fault         sticky memory-timeout flag
//   hz_state          debug state: RUN=0 LOAD_STALL=1 MEM_WAIT=2 FAULT=3
//
// Configuration
//   HAZARD_PERF_EN    when defined, adds saturating counters:
//                       stall_cycles  counts cycles with pc_en=0,
//                                     excluding reset and FAULT
//                       flush_count   counts branch-flush cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 64
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic              mem_fault,
    output logic [1:0]        hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FAULT      = 2'd3
    } state_t;

    // This is what the pipeline does this cycle. The output pattern is
    // decoded from it in exactly one place.
    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_MEM_FREEZE,
        ACT_BRANCH,
        ACT_LOAD,
        ACT_FAULT
    } action_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0] FIRST_LEFT = 2'(LOAD_BUBBLES - 1);

    state_t            r_state;
    state_t            r_ret_state;   // state to resume when MEM_WAIT releases
    logic [1:0]        r_bub_cnt;     // stall cycles left, including the current one
    logic [WAIT_W-1:0] r_wait_cnt;

    state_t            w_next_state;
    state_t            w_next_ret;
    logic [1:0]        w_next_bub;
    logic [WAIT_W-1:0] w_next_wait;
    state_t            w_eff_state;
    action_t           w_act;
    logic              w_load_use;
    logic              w_mem_stall;

    assign w_load_use  = ex_mem_to_reg & ex_reg_write & (ex_dest != '0) &
                         ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
    assign w_mem_stall = mem_req & ~mem_ready;

    // A release from MEM_WAIT is not a free cycle. The pipeline behaves as
    // the interrupted state would, using the bubble count frozen during the
    // wait. A branch held in the frozen EX register is therefore re-evaluated
    // here as well.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    // -------------------------------------------------------------------------
    // Next-state and action selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_ret   = r_ret_state;
        w_next_bub   = r_bub_cnt;
        w_next_wait  = r_wait_cnt;
        w_act        = ACT_RUN;

        if (r_state == ST_FAULT) begin
            w_act = ACT_FAULT;
        end else if (w_mem_stall) begin
            w_act = ACT_MEM_FREEZE;
            if (r_state != ST_MEM_WAIT) begin
                w_next_state = ST_MEM_WAIT;
                w_next_ret   = r_state;
                w_next_wait  = '0;
            end else begin
                w_next_wait = r_wait_cnt + WAIT_W'(1);
                if ((MEM_TIMEOUT != 0) && (w_next_wait == TIMEOUT_V)) begin
                    w_next_state = ST_FAULT;
                end
            end
        end else if (branch_taken) begin
            // The ID instruction is on the wrong path, so any pending or
            // newly detected load stall is dropped.
            w_act        = ACT_BRANCH;
            w_next_state = ST_RUN;
            w_next_bub   = '0;
        end else if (w_eff_state == ST_LOAD_STALL) begin
            w_act = ACT_LOAD;
            if (r_bub_cnt <= 2'd1) begin
                w_next_state = ST_RUN;
                w_next_bub   = '0;
            end else begin
                w_next_state = ST_LOAD_STALL;
                w_next_bub   = r_bub_cnt - 2'd1;
            end
        end else if (w_load_use) begin
            w_act = ACT_LOAD;
            if (LOAD_BUBBLES > 1) begin
                w_next_state = ST_LOAD_STALL;
                w_next_bub   = FIRST_LEFT;
            end else begin
                w_next_state = ST_RUN;
            end
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (reset forces the all-frozen, all-bubble pattern)
    // -------------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;

        if (reset || (w_act == ACT_FAULT)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (w_act)
                ACT_MEM_FREEZE: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                end
                ACT_BRANCH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                ACT_LOAD: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_fault = ~reset & (r_state == ST_FAULT);
    assign hz_state  = reset ? ST_RUN : r_state;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_bub_cnt   <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_bub_cnt   <= w_next_bub;
            r_wait_cnt  <= w_next_wait;
        end
    end

`ifdef HAZARD_PERF_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_pc_stall;

    // Outside reset and FAULT, pc_en is low exactly in these two actions.
    assign w_pc_stall = (w_act == ACT_MEM_FREEZE) || (w_act == ACT_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if ((w_act == ACT_BRANCH) && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Three configurations of pipeline_hazard_ctrl share one input stream:
//   inst 0: LOAD_BUBBLES=1, MEM_TIMEOUT=4
//   inst 1: LOAD_BUBBLES=3, MEM_TIMEOUT=0 (timeout off)
//   inst 2: LOAD_BUBBLES=2, MEM_TIMEOUT=64, CNT_W=2
// Each instance is compared every cycle against a behavioural model. The
// model tracks "stall cycles still owed", "waiting on memory", "cycles
// waited" and "faulted". The stimulus is a directed sequence followed by a
// randomized phase. Define HAZARD_PERF_EN to also check the perf counters.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int LB0 = 1, LB1 = 3, LB2 = 2;
    localparam int TO0 = 4, TO1 = 0, TO2 = 64;
    localparam int CW0 = 16, CW1 = 16, CW2 = 2;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dst;
        logic       m2r;
        logic       rw;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } stim_t;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       idex;
        logic       exmem;
        logic       fl_ifid;
        logic       fl_idex;
        logic       fl_memwb;
        logic       fault;
        logic [1:0] hz;
    } out_t;

    typedef struct {
        bit faulted;
        bit waiting;
        int owed;
        int waited;
        int stalls;
        int flushes;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_uses_rt, ex_mem_to_reg, ex_reg_write, branch_taken, mem_req, mem_ready;

    logic [2:0] pc_en, ifid_en, idex_en, exmem_en;
    logic [2:0] ifid_flush, idex_flush, memwb_flush, mem_fault;
    logic [1:0] hz [3];
`ifdef HAZARD_PERF_EN
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;
`endif

    pipeline_hazard_ctrl #(
        .REG_AW(5), .LOAD_BUBBLES(LB0), .MEM_TIMEOUT(TO0)
`ifdef HAZARD_PERF_EN
        , .CNT_W(CW0)
`endif
    ) u_inst0 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dest(ex_dest), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .memwb_flush(memwb_flush[0]),
        .mem_fault(mem_fault[0]), .hz_state(hz[0])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc0), .flush_count(fc0)
`endif
    );

    pipeline_hazard_ctrl #(
        .REG_AW(5), .LOAD_BUBBLES(LB1), .MEM_TIMEOUT(TO1)
`ifdef HAZARD_PERF_EN
        , .CNT_W(CW1)
`endif
    ) u_inst1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dest(ex_dest), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .memwb_flush(memwb_flush[1]),
        .mem_fault(mem_fault[1]), .hz_state(hz[1])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc1), .flush_count(fc1)
`endif
    );

    pipeline_hazard_ctrl #(
        .REG_AW(5), .LOAD_BUBBLES(LB2), .MEM_TIMEOUT(TO2)
`ifdef HAZARD_PERF_EN
        , .CNT_W(CW2)
`endif
    ) u_inst2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dest(ex_dest), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en[2]), .ifid_en(ifid_en[2]), .idex_en(idex_en[2]), .exmem_en(exmem_en[2]),
        .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .memwb_flush(memwb_flush[2]),
        .mem_fault(mem_fault[2]), .hz_state(hz[2])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc2), .flush_count(fc2)
`endif
    );

    int   lb_p [3] = '{LB0, LB1, LB2};
    int   to_p [3] = '{TO0, TO1, TO2};
    int   cw_p [3] = '{CW0, CW1, CW2};
    mdl_t m [3];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_step = 0;

    // Behavioural reference: one cycle for instance i. It returns the
    // expected outputs for this cycle and advances the model to the next one.
    task automatic model_cycle(input int i, input stim_t s, output out_t e);
        bit lu, ms;
        int sat;
        sat = (1 << cw_p[i]) - 1;
        lu  = s.m2r && s.rw && (s.dst != 5'd0) &&
              ((s.dst == s.rs) || (s.urt && (s.dst == s.rt)));
        ms  = s.mreq && !s.mrdy;
        e   = '0;
        if (s.rst) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1; e.fl_memwb = 1'b1;
            m[i] = '{default: 0};
        end else if (m[i].faulted) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1; e.fl_memwb = 1'b1;
            e.fault = 1'b1; e.hz = 2'd3;
        end else begin
            e.hz = m[i].waiting ? 2'd2 : ((m[i].owed > 0) ? 2'd1 : 2'd0);
            e.pc = 1'b1; e.ifid = 1'b1; e.idex = 1'b1; e.exmem = 1'b1;
            if (ms) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.exmem = 1'b0;
                e.fl_memwb = 1'b1;
                if (m[i].waiting) begin
                    m[i].waited++;
                    if ((to_p[i] != 0) && (m[i].waited == to_p[i])) m[i].faulted = 1'b1;
                end else begin
                    m[i].waiting = 1'b1;
                    m[i].waited  = 0;
                end
            end else begin
                m[i].waiting = 1'b0;
                if (s.br) begin
                    e.fl_ifid = 1'b1; e.fl_idex = 1'b1;
                    m[i].owed = 0;
                    if (m[i].flushes < sat) m[i].flushes++;
                end else if (m[i].owed > 0) begin
                    e.pc = 1'b0; e.ifid = 1'b0; e.fl_idex = 1'b1;
                    m[i].owed--;
                end else if (lu) begin
                    e.pc = 1'b0; e.ifid = 1'b0; e.fl_idex = 1'b1;
                    m[i].owed = lb_p[i] - 1;
                end
            end
            if (!e.pc && (m[i].stalls < sat)) m[i].stalls++;
        end
    endtask

    function automatic out_t observe(input int i);
        out_t o;
        o.pc       = pc_en[i];
        o.ifid     = ifid_en[i];
        o.idex     = idex_en[i];
        o.exmem    = exmem_en[i];
        o.fl_ifid  = ifid_flush[i];
        o.fl_idex  = idex_flush[i];
        o.fl_memwb = memwb_flush[i];
        o.fault    = mem_fault[i];
        o.hz       = hz[i];
        return o;
    endfunction

`ifdef HAZARD_PERF_EN
    function automatic logic [15:0] obs_stalls(input int i);
        case (i)
            0:       return sc0;
            1:       return sc1;
            default: return {14'd0, sc2};
        endcase
    endfunction

    function automatic logic [15:0] obs_flushes(input int i);
        case (i)
            0:       return fc0;
            1:       return fc1;
            default: return {14'd0, fc2};
        endcase
    endfunction
`endif

    // Apply one cycle of stimulus and check every instance mid-cycle.
    task automatic step(input stim_t s);
        out_t e, o;
        @(negedge clk);
        reset         = s.rst;
        id_rs         = s.rs;
        id_rt         = s.rt;
        id_uses_rt    = s.urt;
        ex_dest       = s.dst;
        ex_mem_to_reg = s.m2r;
        ex_reg_write  = s.rw;
        branch_taken  = s.br;
        mem_req       = s.mreq;
        mem_ready     = s.mrdy;
        #1;
        n_step++;
        for (int i = 0; i < 3; i++) begin
`ifdef HAZARD_PERF_EN
            // The counters are registered, so they show the model's count
            // before this cycle is accounted for.
            n_vec++;
            assert (obs_stalls(i) === 16'(m[i].stalls)) else begin
                n_err++;
                $error("FAIL stall_cycles[%0d] step %0d: observed %0d expected %0d",
                       i, n_step, obs_stalls(i), m[i].stalls);
            end
            n_vec++;
            assert (obs_flushes(i) === 16'(m[i].flushes)) else begin
                n_err++;
                $error("FAIL flush_count[%0d] step %0d: observed %0d expected %0d",
                       i, n_step, obs_flushes(i), m[i].flushes);
            end
`endif
            model_cycle(i, s, e);
            o = observe(i);
            n_vec++;
            assert (o === e) else begin
                n_err++;
                $error("FAIL ctrl[%0d] step %0d: observed %b expected %b (pc ifid idex exmem fl_ifid fl_idex fl_memwb fault hz)",
                       i, n_step, o, e);
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ld_use(input logic [4:0] d);
        stim_t s;
        s     = '0;
        s.m2r = 1'b1;
        s.rw  = 1'b1;
        s.dst = d;
        s.rs  = d;
        s.rt  = 5'd31;
        return s;
    endfunction

    stim_t s;

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        reset = 1'b1;
        {id_rs, id_rt, ex_dest} = '0;
        {id_uses_rt, ex_mem_to_reg, ex_reg_write, branch_taken, mem_req, mem_ready} = '0;
        repeat (2) @(posedge clk);

        // Reset state
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        step(idle()); step(idle());

        // Load-use on rs: 1/3/2 stall cycles depending on LOAD_BUBBLES
        step(ld_use(5'd5));
        repeat (4) step(idle());

        // Destination r0 never stalls
        step(ld_use(5'd0));
        repeat (2) step(idle());

        // Hazard through rt only counts when rt is used
        s = ld_use(5'd9); s.rs = 5'd1; s.rt = 5'd9; s.urt = 1'b1;
        step(s);
        repeat (3) step(idle());
        s.urt = 1'b0;
        step(s);
        repeat (2) step(idle());

        // Branch together with load-use: flush wins, no stall afterwards
        s = ld_use(5'd5); s.br = 1'b1;
        step(s);
        repeat (2) step(idle());

        // Memory wait of 5 cycles in the middle of a load stall
        step(ld_use(5'd6));
        s = idle(); s.mreq = 1'b1;
        repeat (5) step(s);
        s.mrdy = 1'b1;
        step(s);
        repeat (3) step(idle());

        // Memory timeout, sticky fault, then recovery through reset
        s = idle(); s.rst = 1'b1;
        step(s);
        s = idle(); s.mreq = 1'b1;
        repeat (8) step(s);
        repeat (3) step(idle());
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());

        // Branch held in EX across a memory wait is applied on release
        s = idle(); s.br = 1'b1; s.mreq = 1'b1;
        repeat (2) step(s);
        s.mrdy = 1'b1;
        step(s);
        step(idle());

        // Three load stalls and two flushes for the perf counters
        s = idle(); s.rst = 1'b1;
        step(s);
        for (int k = 0; k < 3; k++) begin
            step(ld_use(5'd7));
            repeat (3) step(idle());
        end
        for (int k = 0; k < 2; k++) begin
            s = idle(); s.br = 1'b1;
            step(s);
            step(idle());
        end
        step(idle());

        // Randomized traffic with a small register space so hazards are frequent
        for (int k = 0; k < 3000; k++) begin
            s      = '0;
            s.rst  = ($urandom_range(0, 99) == 0);
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.dst  = 5'($urandom_range(0, 3));
            s.urt  = 1'($urandom_range(0, 1));
            s.m2r  = 1'($urandom_range(0, 1));
            s.rw   = ($urandom_range(0, 3) != 0);
            s.br   = ($urandom_range(0, 7) == 0);
            s.mreq = ($urandom_range(0, 2) == 0);
            s.mrdy = 1'($urandom_range(0, 1));
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
